// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one borrow slice, WIDTH shift cycles.
// Start/ack handshake through IDLE -> SHIFT -> DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // one-hot-style codes so BUSY/DONE are plain state bits
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            brw;
  logic [CW-1:0]   cnt;
  logic            diff;
  logic            bout;

  assign diff = a_q[0] ^ b_q[0] ^ brw;
  assign bout = (~a_q[0] & b_q[0])
              | (~(a_q[0] ^ b_q[0]) & brw);

  assign BUSY = state[0];
  assign DONE = state[1];

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      BO    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            a_q   <= A;
            b_q   <= B;
            brw   <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            BO    <= 1'b0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          D   <= {diff, D[WIDTH-1:1]};
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          brw <= bout;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            BO    <= bout;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (ACK) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against
// an arithmetic reference (a - b mod 2^W, borrow = a < b).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK;
  logic         RSTB;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ACK;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D;
  logic         BO;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .START(START),
    .A    (A),
    .B    (B),
    .ACK  (ACK),
    .BUSY (BUSY),
    .DONE (DONE),
    .D    (D),
    .BO   (BO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // launch an op from IDLE and follow it to DONE
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input bit repulse,
                        input bit noise);
    logic [W-1:0] ed;
    logic         eb;
    ed = W'((32'(a) - 32'(b)) & ((1 << W) - 1));
    eb = (a < b);
    START = 1'b1;
    A = a;
    B = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    chk("busy_first", BUSY, 1);
    chk("done_first", DONE, 0);
    for (int i = 1; i < W; i++) begin
      if (repulse && i == 3) begin
        START = 1'b1;
        A = 8'h11;
        B = 8'h22;
      end else begin
        START = noise ? 1'($urandom) : 1'b0;
        A = W'($urandom);
        B = W'($urandom);
      end
      ACK = noise ? 1'($urandom) : 1'b0;
      @(posedge CLK);
      #1;
      chk("busy_shift", BUSY, 1);
      chk("done_shift", DONE, 0);
    end
    START = 1'b0;
    ACK = 1'b0;
    @(posedge CLK);
    #1;
    chk("done_set", DONE, 1);
    chk("busy_clr", BUSY, 0);
    chk("diff", D, ed);
    chk("borrow", BO, eb);
  endtask

  // hold in DONE for n cycles then acknowledge
  task automatic ack_after(input int n);
    logic [W-1:0] hd;
    logic         hb;
    hd = D;
    hb = BO;
    for (int i = 0; i < n; i++) begin
      START = 1'($urandom);
      @(posedge CLK);
      #1;
      chk("hold_done", DONE, 1);
      chk("hold_d", D, hd);
      chk("hold_bo", BO, hb);
    end
    START = 1'b0;
    ACK = 1'b1;
    @(posedge CLK);
    #1;
    ACK = 1'b0;
    chk("ack_idle_done", DONE, 0);
    chk("ack_idle_busy", BUSY, 0);
    chk("ack_keep_d", D, hd);
    chk("ack_keep_bo", BO, hb);
  endtask

  initial begin
    RSTB = 1'b0;
    START = 1'b0;
    ACK = 1'b0;
    A = '0;
    B = '0;
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_d", D, 0);
    chk("rst_bo", BO, 0);
    #20;
    RSTB = 1'b1;
    @(posedge CLK);
    #1;
    chk("idle_busy", BUSY, 0);

    run_op(8'h5A, 8'h3C, 0, 0);
    ack_after(0);
    run_op(8'h00, 8'h01, 0, 0);
    ack_after(1);
    run_op(8'hFF, 8'hFF, 0, 0);
    ack_after(0);

    // restart attempt during SHIFT is ignored
    run_op(8'hC3, 8'h2D, 1, 0);
    ack_after(5);

    // reset in the middle of SHIFT
    START = 1'b1;
    A = 8'hA5;
    B = 8'h5A;
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
    end
    chk("pre_rst_busy", BUSY, 1);
    RSTB = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_done", DONE, 0);
    chk("arst_d", D, 0);
    chk("arst_bo", BO, 0);
    @(negedge CLK);
    RSTB = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_idle", BUSY, 0);
    run_op(8'h80, 8'h01, 0, 0);

    // START together with ACK in DONE: only return to IDLE
    START = 1'b1;
    ACK = 1'b1;
    A = 8'h01;
    B = 8'h02;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ACK = 1'b0;
    chk("sa_done", DONE, 0);
    chk("sa_busy", BUSY, 0);
    chk("sa_keep_d", D, 8'h7F);
    @(posedge CLK);
    #1;
    chk("sa_still_idle", BUSY, 0);
    run_op(8'h10, 8'h20, 0, 0);
    ack_after(2);

    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom), W'($urandom), 0, 1);
      ack_after(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
